// File: rtl/tristate_buffer_pkg.sv
// Shared constants for tri-state bus attachment blocks.
// Bus blocks slice ALL_Z down to their own width.
package tristate_buffer_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 64;

    localparam logic [MAX_WIDTH-1:0] ALL_Z = {MAX_WIDTH{1'bz}};

endpackage

// File: rtl/tristate_buffer_cell.sv
// One-bit combinational tri-state driver.
// An unknown enable merges a and Z, giving X rather than Z.
module tristate_cell
    import tristate_buffer_pkg::*;
(
    input  logic a,
    input  logic en,
    output tri   y
);

    assign y = en ? a : ALL_Z[0];

endmodule

// File: rtl/tristate_buffer.sv
// WIDTH-bit tri-state bus driver, optionally registered.
// drive_active is a clocked copy of the effective enable.
module tristate_buffer
    import tristate_buffer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit REGISTERED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    output tri   [WIDTH-1:0] y,
    output logic             drive_active
);

    logic [WIDTH-1:0] drv_a;
    logic             drv_en;

    if (REGISTERED) begin : g_reg
        logic [WIDTH-1:0] a_q;
        logic             en_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_q  <= '0;
                en_q <= 1'b0;
            end else begin
                a_q  <= a;
                en_q <= en;
            end
        end

        assign drv_a  = a_q;
        assign drv_en = en_q;
    end else begin : g_comb
        assign drv_a  = a;
        assign drv_en = en;
    end

    // en is en_q's next value, so mode 1 tracks en_q exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_active <= 1'b0;
        end else begin
            drive_active <= en;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tristate_cell u_cell (
            .a  (drv_a[i]),
            .en (drv_en),
            .y  (y[i])
        );
    end

endmodule

// File: tb/tb_tristate_buffer.sv
// Bench for tristate_buffer: two combinational drivers and one
// registered driver; a bench-side driver probes bus release.
module tb_tristate_buffer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a0, a1, a2;
    logic         en0, en1, en2;
    logic [W-1:0] tb_v0, tb_v1;
    logic         tb_en0, tb_en1;
    logic         da0, da1, da2;
    tri   [W-1:0] bus0, bus1;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic         md0, md2, m_en1;
    logic [W-1:0] m_a1;
    logic         xprobe;

    assign bus0 = tb_en0 ? tb_v0 : {W{1'bz}};
    assign bus1 = tb_en1 ? tb_v1 : {W{1'bz}};

    always #5 clk = ~clk;

    tristate_buffer #(.WIDTH(W), .REGISTERED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .a(a0), .en(en0),
        .y(bus0), .drive_active(da0)
    );

    tristate_buffer #(.WIDTH(W), .REGISTERED(1'b0)) dut2 (
        .clk(clk), .rst(rst), .a(a2), .en(en2),
        .y(bus0), .drive_active(da2)
    );

    tristate_buffer #(.WIDTH(W), .REGISTERED(1'b1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .en(en1),
        .y(bus1), .drive_active(da1)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs,
                        input logic exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (v) begin
            md0   = 1'b0;
            md2   = 1'b0;
            m_en1 = 1'b0;
            m_a1  = '0;
        end
    endtask

    // advance to just after the next rising edge, updating the model
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            md0 = 1'b0; md2 = 1'b0; m_en1 = 1'b0; m_a1 = '0;
        end else begin
            md0 = en0; md2 = en2; m_en1 = en1; m_a1 = a1;
        end
        #1;
    endtask

    // shared bus 0: whichever single source is enabled owns it
    task automatic check0(input string tag);
        logic [W-1:0] exp;
        if (en0) begin
            exp = a0;
        end else if (en2) begin
            exp = a2;
        end else begin
            tb_v0  = ~a0;
            tb_en0 = 1'b1;
            exp    = tb_v0;
        end
        #1;
        chk(tag, bus0, exp);
        tb_en0 = 1'b0;
    endtask

    task automatic check1(input string tag);
        logic [W-1:0] exp;
        if (m_en1) begin
            exp = m_a1;
        end else begin
            tb_v1  = W'($urandom);
            tb_en1 = 1'b1;
            exp    = tb_v1;
        end
        #1;
        chk(tag, bus1, exp);
        chk1({tag, "_da"}, da1, m_en1);
        tb_en1 = 1'b0;
    endtask

    initial begin
        tb_en0 = 1'b0; tb_en1 = 1'b0;
        tb_v0 = '0; tb_v1 = '0;
        a0 = 4'b0001; en0 = 1'b0;
        a2 = 4'b0000; en2 = 1'b0;
        a1 = 4'b0000; en1 = 1'b0;
        set_rst(1'b1);
        #1;
        chk1("rst_da0", da0, 1'b0);
        chk1("rst_da2", da2, 1'b0);
        check1("rst_y1");
        set_rst(1'b0);

        // combinational mode: release, then drive with no edge
        #100;
        check0("comb_off");
        en0 = 1'b1;
        check0("comb_on_0001");
        tick();
        chk1("comb_da_on", da0, md0);
        a0 = 4'b1010;
        check0("comb_1010");
        a0 = 4'b1111;
        check0("comb_1111");
        tick();
        en0 = 1'b0;
        check0("comb_dis_1111");
        a0 = 4'b0101;
        check0("comb_dis_0101");
        tick();
        chk1("comb_da_off", da0, md0);

        // pessimistic unknown enable, only meaningful in 4-state
        xprobe = 1'bx;
        if (xprobe === 1'bx) begin
            en0 = 1'bx;
            #1;
            chk("comb_en_x", bus0, 4'bxxxx);
            en0 = 1'b0;
            check0("comb_en_x_off");
        end
        tick();

        // two instances on one bus
        en2 = 1'b1; a2 = 4'b1100;
        check0("bus_dut2");
        en2 = 1'b0; en0 = 1'b1; a0 = 4'b0011;
        check0("bus_dut0");
        tick();
        en0 = 1'b0;

        // registered mode
        set_rst(1'b1);
        #2;
        set_rst(1'b0);
        a1 = 4'b0110; en1 = 1'b1;
        check1("reg_pre_edge");
        tick();
        check1("reg_first_edge");
        #1;
        set_rst(1'b1);
        check1("reg_async_rst");
        chk1("reg_rst_da0", da0, 1'b0);
        a1 = 4'b1001;
        tick();
        check1("reg_rst_held");
        set_rst(1'b0);
        a1 = 4'b0011; en1 = 1'b1;
        tick();
        check1("reg_after_rel");
        en1 = 1'b0;
        tick();
        check1("reg_disable");

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(2));
            a0  = W'($urandom);
            a2  = W'($urandom);
            a1  = W'($urandom);
            en0 = (sel == 0);
            en2 = (sel == 1);
            en1 = 1'($urandom);
            check0("rnd_comb_now");
            if ($urandom_range(7) == 0) begin
                set_rst(1'b1);
                check1("rnd_rst");
                set_rst(1'b0);
            end
            tick();
            check0("rnd_comb");
            check1("rnd_reg");
            chk1("rnd_da0", da0, md0);
            chk1("rnd_da2", da2, md2);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tristate_buffer.md
Name: tristate_buffer

Overview:
- Parameterised tri-state bus driver: drives a WIDTH-bit data word onto a shared bus when enabled, otherwise releases the bus to high impedance.
- Used at shared-bus attachment points, e.g. multiple sources on one wire bundle.
- Default configuration is purely combinational from a/en to y.
- An optional registered mode and a drive-status flag use the single clock and reset.

Parameters:
- WIDTH, 4, bit width of data input and bus output.
- REGISTERED, 0, 0 = combinational path from a/en to y; 1 = a and en captured on rising clk before driving y.

Ports:
- clk  input  1  system clock; only REGISTERED mode and the status flag depend on it.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  data to drive onto the bus.
- en  input  1  output enable, active-high.
- y  output (tri)  WIDTH  bus output; equals the data word when enabled, all-Z when disabled.
- drive_active  output  1  registered copy of the effective enable; high while the block drives y.

Behaviour:
- REGISTERED=0:
  - y = a when en=1; y = all-Z when en=0.
  - Purely combinational, zero latency; a change on a while en=1 appears on y in the same delta/timestep.
  - clk and rst do not affect y.
  - en=X or Z: y = all-X (pessimistic), never Z.
- REGISTERED=1:
  - On rising clk: a_q <= a, en_q <= en.
  - y = a_q when en_q=1, else all-Z.
  - One-cycle latency from a/en to y.
  - rst asserted (async, no clock needed): en_q <= 0, a_q <= 0, so y goes all-Z immediately.
  - While rst is held high: y stays all-Z and input changes are ignored.
  - On rst release: the first rising clk captures the current a/en.
- drive_active, both modes:
  - Flop clocked by clk, async reset to 0.
  - Each rising clk samples the effective enable: en in mode 0, en_q's next value in mode 1. In mode 1 it therefore tracks en_q exactly.
- Reset values: drive_active=0; y=all-Z in REGISTERED=1; y follows en/a in REGISTERED=0, since that path is unclocked.
- Bus contention is not resolved inside the block; external drivers combine per standard wired resolution.
- Each bit is independent; there are no partial-enable modes (a single en gates all WIDTH bits).
- Implementation:
  - Generate-select between the two modes.
  - The Z assignment is the only tri-state construct.
  - No latches; all flops use async reset on rst.

Decomposition:
- Shared package: a localparam constant for the all-Z pattern, and the default WIDTH constant, reused by other bus blocks.
- One natural sub-module, tristate_cell: a 1-bit combinational tri-state driver, instantiated WIDTH times by generate.
- The registered front end and the status flop stay in the top module.

Test Plan:
- REGISTERED=0, a=4'b0001, en=0 for 100 ns -> y=4'bzzzz; then en=1 -> y=4'b0001 with no clock edge.
- REGISTERED=0, en=1, a steps 0001 -> 1010 -> 1111 -> y follows each value immediately; en=0 -> y=zzzz regardless of a.
- REGISTERED=1, rst pulse, then a=4'b0110, en=1 before a clk edge -> y=zzzz until the edge; after the first rising clk y=0110 and drive_active=1.
- REGISTERED=1, driving 0110, rst asserted mid-cycle without a clock -> y=zzzz and drive_active=0 at once; after release the next clk with en=1, a=0011 -> y=0011.
- REGISTERED=0, en=X -> y=xxxx; en=0 -> y=zzzz. Two instances on one bus with one enabled -> bus shows the enabled instance's data.
